az_sequencer: RTL and testbench
===============================

# az_sequencer

Auto-zero sequencer for the dmm ADC. It alternates the input mux between the signal (hi) and zero (lo) references, waits a programmable settle time, triggers the ADC, and waits for the ADC's valid. Each completed conversion is tagged with its phase and announced to downstream logic. It sits between the register bank and the ADC; it is the only block that drives the ADC trigger.

## Interface

- No parameters. Widths are fixed.
- `clk` in 1: system clock. Every flop is on posedge `clk`.
- `reset_n` in 1: asynchronous, active-low reset.
- `run` in 1: level input. 1 runs the sequencer continuously; 0 stops or aborts it.
- `az_enable` in 1: 1 alternates hi and lo phases; 0 stays on hi only.
- `clk_settle_duration` in 32: settle count after each mux change. Sampled on entry to SETTLE.
- `clk_timeout` in 32: maximum number of MEASURE cycles. Sampled on entry to MEASURE.
- `adc_measure_valid` in 1: ADC completion level. It is cleared by the ADC on the edge at which it samples a trigger.
- `adc_measure_trig` out 1: registered ADC start, exactly one cycle high.
- `az_mux` out 1: registered mux select. 0 = signal/hi, 1 = zero/lo.
- `sample_valid` out 1: one-cycle pulse when a conversion completes.
- `sample_is_lo` out 1: phase of the completed conversion. Valid while `sample_valid` = 1.
- `sample_count` out 16: completed-conversion counter. Wraps 0xFFFF -> 0.
- `err_timeout` out 1: sticky error flag.
- `monitor` out 6: bits {state[2:0], az_mux, adc_measure_valid, adc_measure_trig}.

## Operation

- Reset values:
  - state = IDLE.
  - `adc_measure_trig`, `az_mux`, `sample_valid`, `sample_is_lo`, `err_timeout` = 0.
  - `sample_count` = 0, and both counters = 0.
- States (3-bit encoding): IDLE=0, SETTLE=1, TRIG=2, MEASURE=3, DONE=4, ERROR=5.
- IDLE:
  - `az_mux` = 0.
  - If `run` = 1, go to SETTLE, with count = `clk_settle_duration` and phase = hi.
- SETTLE:
  - `az_mux` = phase.
  - Count decrements each cycle.
  - When count == 0, go to TRIG.
- TRIG:
  - `adc_measure_trig` = 1 for this one cycle.
  - Go to MEASURE, with timeout counter = `clk_timeout`.
- MEASURE:
  - `adc_measure_valid` is ignored on the first MEASURE cycle, because the ADC clears it on that edge.
  - From the second cycle, `adc_measure_valid` = 1 moves the block to DONE.
  - Otherwise the timeout counter decrements. When it reaches 0 with no valid, go to ERROR.
- DONE, lasting one cycle:
  - `sample_valid` = 1 and `sample_is_lo` = phase.
  - `sample_count` increments.
  - Phase toggles if `az_enable` = 1, else it is forced to hi.
  - Go to SETTLE and reload the count.
- ERROR:
  - `err_timeout` = 1 and `az_mux` = 0.
  - Stays in ERROR until `run` = 0, then goes to IDLE.
  - `err_timeout` stays set until the next IDLE -> SETTLE transition, where it clears.
- `run` = 0 in SETTLE, TRIG, MEASURE or DONE aborts to IDLE on the next edge:
  - No `sample_valid` is issued, except in DONE, where the pulse still completes.
  - A trigger already issued is not retracted. The ADC result is discarded.
- `az_enable` is sampled only in DONE. A change mid-conversion takes effect on the following conversion.
- `reset_n` low at any time forces the reset values immediately, independent of `clk`.

## Timing

- From `run` rising (sampled at edge E) to `adc_measure_trig` high: `clk_settle_duration` + 2 edges. Settle = 0 means SETTLE lasts one cycle.
- `az_mux` changes on the same edge that enters SETTLE, so the settle window covers the mux change.
- Trigger to DONE: conversion length + 1 cycle.
- Full hi/lo pair period: 2 × (settle + 1 + 1 + MEASURE cycles + 1).
- `sample_valid` is high exactly one cycle. `sample_count` shows the incremented value on the edge after the pulse.
- The timeout fires after `clk_timeout` + 1 MEASURE cycles with no valid. With `clk_timeout` = 0, the block goes to ERROR after the first MEASURE cycle.

## Test plan

- **Normal az run:** reset, then `run`=1, `az_enable`=1, settle=3, ADC model duration 10.
  - Trigger occurs 5 cycles after `run`.
  - `sample_is_lo` alternates 0,1,0,1 over 4 samples.
  - `sample_count`=4.
  - `az_mux` toggles only on SETTLE entry.
- **Non-az run:** `az_enable`=0 with the same settings.
  - `az_mux` stays 0.
  - All `sample_is_lo`=0.
  - Exactly one trigger per sample.
- **Timeout:** ADC model never asserts valid, `clk_timeout`=20.
  - ERROR entered 21 cycles after MEASURE entry, with `err_timeout`=1 and `az_mux`=0.
  - Drop `run`: state goes to IDLE.
  - Re-raise `run`: `err_timeout` clears.
- **Abort:** drop `run` mid-MEASURE.
  - State goes to IDLE next edge.
  - No `sample_valid`; `sample_count` unchanged.
- **Async reset:** pulse `reset_n` low mid-SETTLE, between clock edges.
  - All outputs go to reset values immediately.
- **Wrap:** preload or force `sample_count` to 0xFFFF, then complete one sample.
  - Count becomes 0x0000.
  - `sample_valid` still pulses.

Source files
------------

// File: rtl/az_sequencer_if.sv
// az_sequencer_if: control, ADC handshake and sample-report signals of the auto-zero sequencer.
interface az_sequencer_if;
  logic        run;
  logic        az_enable;
  logic [31:0] clk_settle_duration;
  logic [31:0] clk_timeout;
  logic        adc_measure_valid;
  logic        adc_measure_trig;
  logic        az_mux;
  logic        sample_valid;
  logic        sample_is_lo;
  logic [15:0] sample_count;
  logic        err_timeout;
  logic [5:0]  monitor;
  modport master (
    output run, az_enable, clk_settle_duration, clk_timeout, adc_measure_valid,
    input  adc_measure_trig, az_mux, sample_valid, sample_is_lo, sample_count, err_timeout, monitor
  );
  modport slave (
    input  run, az_enable, clk_settle_duration, clk_timeout, adc_measure_valid,
    output adc_measure_trig, az_mux, sample_valid, sample_is_lo, sample_count, err_timeout, monitor
  );
endinterface

// File: rtl/az_sequencer.sv
// az_sequencer: alternates the ADC input mux between hi/lo, settles, triggers the ADC and reports tagged samples.
module az_sequencer (
  input logic           clk,
  input logic           reset_n,
  az_sequencer_if.slave az
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    TRIG    = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_t;
  state_t      state_q;
  logic [31:0] cnt_q;
  logic [31:0] tmo_q;
  logic        first_q;
  logic        phase_q;
  logic        trig_q;
  logic        mux_q;
  logic        sv_q;
  logic        lo_q;
  logic        err_q;
  logic [15:0] sample_count_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tmo_q          <= '0;
      first_q        <= 1'b0;
      phase_q        <= 1'b0;
      trig_q         <= 1'b0;
      mux_q          <= 1'b0;
      sv_q           <= 1'b0;
      lo_q           <= 1'b0;
      err_q          <= 1'b0;
      sample_count_q <= '0;
    end else begin
      trig_q <= 1'b0;
      sv_q   <= 1'b0;
      case (state_q)
        IDLE: if (az.run) begin
          state_q <= SETTLE;
          cnt_q   <= az.clk_settle_duration;
          phase_q <= 1'b0;
          mux_q   <= 1'b0;
          err_q   <= 1'b0;
        end
        SETTLE: if (cnt_q == 32'd0) begin
          state_q <= TRIG;
          trig_q  <= 1'b1;
        end else cnt_q <= cnt_q - 32'd1;
        TRIG: begin
          state_q <= MEASURE;
          tmo_q   <= az.clk_timeout;
          first_q <= 1'b1;
        end
        MEASURE: begin
          first_q <= 1'b0;
          // valid is stale on the first cycle: the ADC clears it on the edge that samples the trigger
          if (!first_q && az.adc_measure_valid) begin
            state_q <= DONE;
            sv_q    <= 1'b1;
            lo_q    <= phase_q;
          end else if (tmo_q == 32'd0) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
            mux_q   <= 1'b0;
          end else tmo_q <= tmo_q - 32'd1;
        end
        DONE: begin
          sample_count_q <= sample_count_q + 16'd1;
          phase_q        <= az.az_enable & ~phase_q;
          mux_q          <= az.az_enable & ~phase_q;
          cnt_q          <= az.clk_settle_duration;
          state_q        <= SETTLE;
        end
        ERROR: if (!az.run) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // abort overrides any transition, new trigger or new sample taken this cycle
      if (!az.run && state_q inside {SETTLE, TRIG, MEASURE, DONE}) begin
        state_q <= IDLE;
        mux_q   <= 1'b0;
        trig_q  <= 1'b0;
        sv_q    <= 1'b0;
      end
    end
  end
  assign az.adc_measure_trig = trig_q;
  assign az.az_mux           = mux_q;
  assign az.sample_valid     = sv_q;
  assign az.sample_is_lo     = lo_q;
  assign az.sample_count     = sample_count_q;
  assign az.err_timeout      = err_q;
  assign az.monitor          = {state_q, mux_q, az.adc_measure_valid, trig_q};
endmodule

// File: tb/tb_az_sequencer.sv
// tb_az_sequencer: directed checks of the auto-zero sequencer against a simple ADC model.
module tb_az_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  az_sequencer_if az();
  az_sequencer dut (.clk(clk), .reset_n(reset_n), .az(az));
  always #5 clk = ~clk;
  // ADC model: valid drops when the trigger is sampled, rises dur cycles later if enabled
  logic adc_valid = 1'b0;
  logic adc_en = 1'b1;
  int adc_cnt = 0;
  int dur = 10;
  int trigs = 0;
  assign az.adc_measure_valid = adc_valid;
  always @(posedge clk) begin
    if (az.adc_measure_trig) begin
      adc_valid <= 1'b0;
      adc_cnt   <= dur;
      trigs     <= trigs + 1;
    end else if (adc_cnt > 1) adc_cnt <= adc_cnt - 1;
    else if (adc_cnt == 1) begin
      adc_cnt   <= 0;
      adc_valid <= adc_en;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_sv(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!az.sample_valid && n < 300);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    int t0;
    logic seen;
    az.run = 1'b0;
    az.az_enable = 1'b1;
    az.clk_settle_duration = 32'd3;
    az.clk_timeout = 32'd100;
    #1 reset_n = 1'b0;
    step(2);
    chk("rst_state", 32'(az.monitor[5:3]), 32'd0);
    chk("rst_trig", 32'(az.adc_measure_trig), 32'd0);
    chk("rst_mux", 32'(az.az_mux), 32'd0);
    chk("rst_sv", 32'(az.sample_valid), 32'd0);
    chk("rst_lo", 32'(az.sample_is_lo), 32'd0);
    chk("rst_count", 32'(az.sample_count), 32'd0);
    chk("rst_err", 32'(az.err_timeout), 32'd0);
    reset_n = 1'b1;
    step(1);
    // normal auto-zero run
    az.run = 1'b1;
    step(4);
    chk("az_settle_state", 32'(az.monitor[5:3]), 32'd1);
    chk("az_trig_early", 32'(az.adc_measure_trig), 32'd0);
    step(1);
    chk("az_trig_at5", 32'(az.adc_measure_trig), 32'd1);
    chk("az_trig_state", 32'(az.monitor[5:3]), 32'd2);
    wait_sv(n);
    chk("az_trig_to_sv", 32'(n), 32'd12);
    chk("az_lo0", 32'(az.sample_is_lo), 32'd0);
    chk("az_count_lag", 32'(az.sample_count), 32'd0);
    step(1);
    chk("az_sv_pulse", 32'(az.sample_valid), 32'd0);
    chk("az_count1", 32'(az.sample_count), 32'd1);
    chk("az_mux_lo", 32'(az.az_mux), 32'd1);
    chk("az_settle2", 32'(az.monitor[5:3]), 32'd1);
    step(4);
    chk("az_trig2", 32'(az.adc_measure_trig), 32'd1);
    chk("az_mux_hold", 32'(az.az_mux), 32'd1);
    wait_sv(n);
    chk("az_trig_to_sv2", 32'(n), 32'd12);
    chk("az_lo1", 32'(az.sample_is_lo), 32'd1);
    wait_sv(n);
    chk("az_period3", 32'(n), 32'd17);
    chk("az_lo2", 32'(az.sample_is_lo), 32'd0);
    wait_sv(n);
    chk("az_period4", 32'(n), 32'd17);
    chk("az_lo3", 32'(az.sample_is_lo), 32'd1);
    step(1);
    chk("az_count4", 32'(az.sample_count), 32'd4);
    chk("az_mux_hi", 32'(az.az_mux), 32'd0);
    az.run = 1'b0;
    step(1);
    chk("az_stop", 32'(az.monitor[5:3]), 32'd0);
    // hi-only run
    az.az_enable = 1'b0;
    t0 = trigs;
    az.run = 1'b1;
    step(5);
    chk("naz_trig", 32'(az.adc_measure_trig), 32'd1);
    for (int i = 0; i < 3; i++) begin
      wait_sv(n);
      chk("naz_sv_seen", 32'(az.sample_valid), 32'd1);
      chk("naz_lo", 32'(az.sample_is_lo), 32'd0);
      chk("naz_mux", 32'(az.az_mux), 32'd0);
    end
    chk("naz_trigs", 32'(trigs - t0), 32'd3);
    step(1);
    chk("naz_count7", 32'(az.sample_count), 32'd7);
    chk("naz_mux_settle", 32'(az.az_mux), 32'd0);
    az.run = 1'b0;
    step(1);
    // timeout
    adc_en = 1'b0;
    az.clk_timeout = 32'd20;
    az.run = 1'b1;
    step(5);
    chk("to_trig", 32'(az.adc_measure_trig), 32'd1);
    step(21);
    chk("to_still_measure", 32'(az.monitor[5:3]), 32'd3);
    step(1);
    chk("to_error_monitor", 32'(az.monitor), 32'b101000);
    chk("to_err", 32'(az.err_timeout), 32'd1);
    az.run = 1'b0;
    step(1);
    chk("to_idle", 32'(az.monitor[5:3]), 32'd0);
    chk("to_err_sticky", 32'(az.err_timeout), 32'd1);
    az.run = 1'b1;
    step(1);
    chk("to_rerun_state", 32'(az.monitor[5:3]), 32'd1);
    chk("to_err_clear", 32'(az.err_timeout), 32'd0);
    az.run = 1'b0;
    step(1);
    // abort mid-measure
    adc_en = 1'b1;
    az.clk_timeout = 32'd100;
    az.run = 1'b1;
    step(5);
    step(3);
    chk("ab_measure", 32'(az.monitor[5:3]), 32'd3);
    az.run = 1'b0;
    step(1);
    chk("ab_idle", 32'(az.monitor[5:3]), 32'd0);
    seen = az.sample_valid;
    for (int i = 0; i < 20; i++) begin
      step(1);
      seen = seen | az.sample_valid;
    end
    chk("ab_no_sv", 32'(seen), 32'd0);
    chk("ab_count", 32'(az.sample_count), 32'd7);
    // asynchronous reset between edges
    az.clk_settle_duration = 32'd10;
    az.run = 1'b1;
    step(3);
    chk("ar_settle", 32'(az.monitor[5:3]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_state", 32'(az.monitor[5:3]), 32'd0);
    chk("ar_count", 32'(az.sample_count), 32'd0);
    az.run = 1'b0;
    #1 reset_n = 1'b1;
    step(1);
    // counter wrap
    force dut.sample_count_q = 16'hFFFF;
    step(1);
    release dut.sample_count_q;
    step(1);
    chk("wr_preload", 32'(az.sample_count), 32'hFFFF);
    az.az_enable = 1'b1;
    az.clk_settle_duration = 32'd3;
    az.run = 1'b1;
    wait_sv(n);
    chk("wr_run_to_sv", 32'(n), 32'd17);
    chk("wr_sv", 32'(az.sample_valid), 32'd1);
    step(1);
    chk("wr_count0", 32'(az.sample_count), 32'd0);
    chk("wr_sv_end", 32'(az.sample_valid), 32'd0);
    az.run = 1'b0;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
